// File: rtl/sub_serial_clk.sv
// Bit-serial subtractor d = a - b - bi, one bit per clock, LSB first, through a single full-adder slice.
// Latency: done pulses in the cycle after the WIDTH-th edge following acceptance; one op per WIDTH+2 cycles.
// Backpressure: start is sampled only in IDLE and is never queued; busy is high while an operation is in flight.
//
// Ports:
//   clock, reset_n      rising-edge clock, synchronous active-low reset
//   start, a, b, bi     request and operands (captured on the accepting edge)
//   busy, done          status: busy while not IDLE, done is a one-cycle result strobe
//   d, bo, ov           difference, unsigned borrow out, signed overflow (held until next result)
module sub_serial_clk #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bi,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             bo,
    output logic             ov
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_opa;
    logic [WIDTH-1:0] r_opb;     // holds ~b so the slice always adds
    logic             r_carry;   // holds ~borrow
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_res;
    logic             r_a_msb;
    logic             r_b_msb;   // original (uninverted) MSB of b
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_d;
    logic             r_bo;
    logic             r_ov;

    // Full-adder slice on the current LSBs
    logic             w_sum;
    logic             w_carry_nxt;
    logic [WIDTH-1:0] w_res_nxt;

    assign w_sum       = r_opa[0] ^ r_opb[0] ^ r_carry;
    assign w_carry_nxt = (r_opa[0] & r_opb[0]) | (r_opa[0] & r_carry) | (r_opb[0] & r_carry);
    // Sum bits enter at the MSB and walk down, so after WIDTH shifts bit 0 lands at index 0
    assign w_res_nxt   = {w_sum, r_res[WIDTH-1:1]};

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_opa   <= '0;
            r_opb   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_res   <= '0;
            r_a_msb <= 1'b0;
            r_b_msb <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_d     <= '0;
            r_bo    <= 1'b0;
            r_ov    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_opa   <= a;
                        r_opb   <= ~b;
                        r_carry <= ~bi;
                        r_a_msb <= a[WIDTH-1];
                        r_b_msb <= b[WIDTH-1];
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_res   <= w_res_nxt;
                    r_carry <= w_carry_nxt;
                    r_opa   <= {1'b0, r_opa[WIDTH-1:1]};
                    r_opb   <= {1'b0, r_opb[WIDTH-1:1]};
                    if (r_cnt == LAST) begin
                        // Final bit: publish result; carry out of a + ~b + ~bi is ~borrow
                        r_cnt   <= '0;
                        r_d     <= w_res_nxt;
                        r_bo    <= ~w_carry_nxt;
                        r_ov    <= (r_a_msb != r_b_msb) && (w_res_nxt[WIDTH-1] != r_a_msb);
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign d    = r_d;
    assign bo   = r_bo;
    assign ov   = r_ov;

endmodule

// File: tb/tb_sub_serial_clk.sv
// Directed bench for sub_serial_clk (WIDTH=32): reset, borrow/overflow corners,
// handshake behaviour, mid-run reset and a random sweep against a - b - bi.
module tb_sub_serial_clk;

    localparam int W = 32;

    logic         clock;
    logic         reset_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bi;
    logic         busy;
    logic         done;
    logic [W-1:0] d;
    logic         bo;
    logic         ov;

    int checks = 0;
    int errors = 0;

    sub_serial_clk #(.WIDTH(W)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .bi      (bi),
        .busy    (busy),
        .done    (done),
        .d       (d),
        .bo      (bo),
        .ov      (ov)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one edge and sample 1 time unit later
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // One full operation starting from IDLE (caller is #1 after an edge).
    // mess=1 re-asserts start with new operands mid-run to prove they are ignored.
    task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tbi,
                         input bit mess, input bit full);
        logic [W:0]   ref_full;
        logic [W-1:0] ref_d;
        logic         ref_bo, ref_ov;
        int           n;
        int           busy_cnt;
        ref_full = {1'b0, ta} - {1'b0, tb_v} - {{W{1'b0}}, tbi};
        ref_d    = ref_full[W-1:0];
        ref_bo   = ref_full[W];
        ref_ov   = (ta[W-1] != tb_v[W-1]) && (ref_d[W-1] != ta[W-1]);

        a = ta; b = tb_v; bi = tbi; start = 1'b1;
        tick();                       // accepting edge E0
        start = 1'b0;
        n = 0;
        busy_cnt = busy ? 1 : 0;
        while (!done && n < 40) begin
            if (mess && n == 5) begin
                a = 32'd9; b = 32'd9; bi = ~tbi; start = 1'b1;
            end
            if (mess && n == 12) begin
                start = 1'b0; a = $urandom; b = $urandom;
            end
            tick();
            n++;
            if (busy) busy_cnt++;
        end
        check("latency", W'(n), W'(32));
        check("d", d, ref_d);
        check("bo", W'(bo), W'(ref_bo));
        check("ov", W'(ov), W'(ref_ov));
        tick();
        check("done_pulse", W'(done), W'(0));
        if (full) begin
            check("busy_cycles", W'(busy_cnt), W'(33));
            check("busy_idle", W'(busy), W'(0));
            check("d_held", d, ref_d);
        end
    endtask

    initial begin : stim
        int t, t1, t2, pulses;
        reset_n = 1'b0; start = 1'b0; a = '0; b = '0; bi = 1'b0;
        tick(); tick();
        check("rst_busy", W'(busy), W'(0));
        check("rst_done", W'(done), W'(0));
        check("rst_d", d, '0);
        check("rst_bo", W'(bo), W'(0));
        check("rst_ov", W'(ov), W'(0));
        reset_n = 1'b1;
        tick();

        // 1. basic, 2. borrow, 3. signed overflow
        do_op(32'd5, 32'd3, 1'b0, 1'b0, 1'b1);
        check("t1_d", d, 32'h0000_0002);
        do_op(32'd3, 32'd5, 1'b0, 1'b0, 1'b1);
        check("t2_d", d, 32'hFFFF_FFFE);
        check("t2_bo", W'(bo), W'(1));
        do_op(32'd0, 32'd0, 1'b1, 1'b0, 1'b1);
        check("t2b_d", d, 32'hFFFF_FFFF);
        check("t2b_bo", W'(bo), W'(1));
        do_op(32'h8000_0000, 32'd1, 1'b0, 1'b0, 1'b1);
        check("t3_d", d, 32'h7FFF_FFFF);
        check("t3_ov", W'(ov), W'(1));
        do_op(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1);
        check("t3b_d", d, 32'h8000_0000);
        check("t3b_bo", W'(bo), W'(1));
        check("t3b_ov", W'(ov), W'(1));

        // 4. start and operands disturbed mid-run
        do_op(32'd1000, 32'd1, 1'b0, 1'b1, 1'b1);
        check("t4_d", d, 32'd999);

        // 4. start held high: back-to-back pulses every 34 cycles
        a = 32'd20; b = 32'd7; bi = 1'b0; start = 1'b1;
        t = 0; t1 = -1; t2 = -1;
        while (t2 < 0 && t < 120) begin
            tick();
            t++;
            if (done) begin
                check("b2b_d", d, 32'd13);
                if (t1 < 0) t1 = t; else t2 = t;
            end
        end
        start = 1'b0;
        check("b2b_period", W'(t2 - t1), W'(34));
        tick(); tick();
        check("b2b_idle", W'(busy), W'(0));

        // 5. reset at counter=17
        a = 32'd50; b = 32'd8; bi = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 17; i++) tick();
        check("pre_rst_busy", W'(busy), W'(1));
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        check("mid_rst_busy", W'(busy), W'(0));
        check("mid_rst_done", W'(done), W'(0));
        check("mid_rst_d", d, '0);
        check("mid_rst_bo", W'(bo), W'(0));
        check("mid_rst_ov", W'(ov), W'(0));
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done || busy) pulses++;
        end
        check("no_done_after_rst", W'(pulses), W'(0));
        do_op(32'd100, 32'd1, 1'b0, 1'b0, 1'b1);
        check("t5_d", d, 32'd99);

        // 6. random sweep
        for (int i = 0; i < 1000; i++) begin
            do_op($urandom, $urandom, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sub_serial_clk.md
Name: sub_serial_clk

Overview:
- Bit-serial registered subtractor, the inverse direction of the team's registered 32-bit adder datapath.
- Computes d = a - b - bi one bit per clock, LSB first, using a single full-adder slice with a stored carry.
- Trades latency for area. Used where the parallel adder/subtractor is too large and a multi-cycle start/done handshake is acceptable.

Parameters:
- WIDTH, 32, operand/result width in bits; WIDTH >= 2. Bit counter width is ceil(log2(WIDTH)).

Ports:
- clock  input  1  rising-edge clock; the block's only clock.
- reset_n  input  1  reset; synchronous, active-low.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  minuend; captured on the accepting edge.
- b  input  WIDTH  subtrahend; captured on the accepting edge.
- bi  input  1  borrow in; captured on the accepting edge.
- busy  output  1  high while state != IDLE.
- done  output  1  single-cycle pulse; result valid.
- d  output  WIDTH  difference; held until the next accepted start.
- bo  output  1  borrow out (unsigned a < b + bi).
- ov  output  1  signed two's-complement overflow.

Behaviour:
- Reset: reset_n sampled low at a rising edge gives state=IDLE, counter=0, and all internal registers cleared.
  - Outputs after reset: busy=0, done=0, d=0, bo=0, ov=0.
  - Reset applies in any state, including mid-RUN. The partial result is discarded and no done pulse is produced.
- States: IDLE, RUN, DONE. All outputs are registered; there are no combinational paths from inputs to outputs.
- IDLE:
  - start=1 at edge E0 latches the operands: opA=a, opB=~b, carry=~bi, counter=0. Then -> RUN.
  - start=0 stays in IDLE.
- Arithmetic: a - b - bi = a + ~b + ~bi. Final carry=1 means no borrow, so bo = ~carry_final.
- RUN, one bit per edge E1..E_WIDTH:
  - s = opA[0] ^ opB[0] ^ carry.
  - carry = majority(opA[0], opB[0], carry).
  - s is shifted into the result register MSB-side (shift right). opA and opB shift right by one. counter increments.
  - On the edge where counter == WIDTH-1 (edge E_WIDTH): -> DONE.
  - Also on that edge: d = the completed result register, bo = ~carry_next, ov = (a[MSB] != b[MSB]) && (d[MSB] != a[MSB]). The MSBs of a and b are kept from capture time.
- DONE: done=1 for exactly one cycle, then unconditionally -> IDLE.
- Latency: done is high in the cycle after edge E0+WIDTH (WIDTH=32 gives 32 edges after acceptance). Back-to-back throughput is one operation per WIDTH+2 cycles.
- start is ignored in RUN and DONE; it is not queued. A start held high through DONE is accepted on the first IDLE edge.
- a, b, and bi may change freely after the accepting edge; they have no effect on the operation in flight.
- d, bo, and ov change only on the DONE-entry edge or on reset. They are stable from the DONE cycle until the next result.
- busy=1 from the cycle after E0 through the DONE cycle inclusive. busy=0 in IDLE.
- Wrap-around: the result is modulo 2^WIDTH. The borrow is reported only on bo, and the result is never saturated.
- Counter wrap: the counter is reloaded to 0 on acceptance, and its terminal value WIDTH-1 is decoded exactly. It never free-runs past WIDTH-1.

Test Plan:
1. Basic, no borrow: a=5, b=3, bi=0, start pulse.
   - done pulses exactly 32 edges after acceptance.
   - d=0x00000002, bo=0, ov=0, busy=1 for 33 cycles.
2. Borrow: a=3, b=5, bi=0.
   - d=0xFFFFFFFE, bo=1, ov=0.
   - Then a=0, b=0, bi=1: d=0xFFFFFFFF, bo=1, ov=0.
3. Signed overflow:
   - a=0x80000000, b=1: d=0x7FFFFFFF, bo=0, ov=1.
   - a=0x7FFFFFFF, b=0xFFFFFFFF: d=0x80000000, bo=1, ov=1.
4. Handshake:
   - start re-asserted with a=9, b=9 during RUN: ignored; the first result is still returned.
   - Operand inputs changed mid-RUN: the result is unaffected.
   - start held high continuously: back-to-back done pulses with a period of 34 cycles.
5. Reset mid-operation: reset_n=0 at counter=17.
   - The next cycle shows busy=0, done=0, d=0, bo=0, ov=0, with no done pulse.
   - A new a=100, b=1 then gives d=99.
6. Random regression: 1000 random a, b, bi compared against reference a-b-bi.
   - Checks d, bo, and ov.
   - Checks that done is a one-cycle pulse and the latency is exactly 32 edges.
